// File: rtl/risc_cache_pkg.sv
// rtl/risc_cache_pkg.sv - shared types, widths and defaults for the data cache
// Contents: FSM state enum, address field widths/positions, LINES/WORDS defaults,
//           and helpers that split a byte address into offset/index/tag.
package risc_cache_pkg;

    localparam int LINES_DEF  = 32;
    localparam int WORDS_DEF  = 4;

    localparam int OFFSET_W   = 2;
    localparam int INDEX_W    = 5;
    localparam int TAG_W      = 23;

    localparam int OFFSET_LSB = 2;
    localparam int INDEX_LSB  = OFFSET_LSB + OFFSET_W;
    localparam int TAG_LSB    = INDEX_LSB + INDEX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_t;

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [31:0] a);
        return a[INDEX_LSB-1:OFFSET_LSB];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] a);
        return a[TAG_LSB-1:INDEX_LSB];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
        return a[31:TAG_LSB];
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - pipeline and memory-side signals of the data cache
// Ports (slave = cache side):
//   in : addr, wdata, rd_en, wr_en     pipeline request, held stable while stalled
//   out: rdata, stall                  load data and pipeline freeze
//   out: mem_req, mem_we, mem_addr, mem_wdata  memory transaction
//   in : mem_rdata, mem_valid          refill beat / write acknowledge
interface dcache_ctrl_if;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_valid;

    modport slave (
        input  addr, wdata, rd_en, wr_en, mem_rdata, mem_valid,
        output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output addr, wdata, rd_en, wr_en, mem_rdata, mem_valid,
        input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - tag, valid and data storage for a direct-mapped cache
// Ports:
//   clk, rst                          clock, sync active-high reset (clears valid only)
//   rd_index, rd_tag, rd_offset       lookup address fields
//   hit, rd_word                      combinational lookup result
//   wr_word, wr_index, wr_offset, wr_data   single-word data write
//   line_set, line_clr, wr_tag        set line valid with tag / invalidate line
module dcache_array
    import risc_cache_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [TAG_W-1:0]    rd_tag,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic                hit,
    output logic [31:0]         rd_word,
    input  logic                wr_word,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [31:0]         wr_data,
    input  logic                line_set,
    input  logic                line_clr,
    input  logic [TAG_W-1:0]    wr_tag
);

    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES][WORDS];
    logic [LINES-1:0] valid;

    assign hit     = valid[rd_index] && (tag_mem[rd_index] == rd_tag);
    assign rd_word = data_mem[rd_index][rd_offset];

    // Tag and data contents survive reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (wr_word) begin
            data_mem[wr_index][wr_offset] <= wr_data;
        end
        if (line_set) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (line_set) begin
            valid[wr_index] <= 1'b1;
        end else if (line_clr) begin
            valid[wr_index] <= 1'b0;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - write-through, no-write-allocate direct-mapped data cache controller
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  dcache_ctrl_if.slave: pipeline request/response and memory bus
module dcache_ctrl
    import risc_cache_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic          clk,
    input  logic          rst,
    dcache_ctrl_if.slave  bus
);

    state_t        state;
    state_t        next_state;
    logic [1:0]    beat_cnt;

    logic          hit;
    logic [31:0]   rd_word;
    logic          wr_word;
    logic [OFFSET_W-1:0] wr_offset;
    logic [31:0]   wr_data;
    logic          line_set;
    logic          line_clr;

    logic          unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.addr[1:0]};

    dcache_array #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (addr_index(bus.addr)),
        .rd_tag    (addr_tag(bus.addr)),
        .rd_offset (addr_offset(bus.addr)),
        .hit       (hit),
        .rd_word   (rd_word),
        .wr_word   (wr_word),
        .wr_index  (addr_index(bus.addr)),
        .wr_offset (wr_offset),
        .wr_data   (wr_data),
        .line_set  (line_set),
        .line_clr  (line_clr),
        .wr_tag    (addr_tag(bus.addr))
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= 2'd0;
        end else begin
            state <= next_state;
            if (state == REFILL && bus.mem_valid) begin
                beat_cnt <= beat_cnt + 2'd1;
            end else if (state != REFILL) begin
                beat_cnt <= 2'd0;
            end
        end
    end

    // A store takes priority over a load when both are requested.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.wr_en) begin
                    next_state = WRITE;
                end else if (bus.rd_en && !hit) begin
                    next_state = REFILL;
                end
            end
            REFILL: begin
                if (bus.mem_valid && beat_cnt == 2'd3) begin
                    next_state = IDLE;
                end
            end
            WRITE: begin
                if (bus.mem_valid) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.rdata     = 32'd0;
        bus.stall     = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        wr_word       = 1'b0;
        wr_offset     = addr_offset(bus.addr);
        wr_data       = bus.wdata;
        line_set      = 1'b0;
        line_clr      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.wr_en) begin
                    bus.stall = 1'b1;
                end else if (bus.rd_en) begin
                    if (hit) begin
                        bus.rdata = rd_word;
                    end else begin
                        bus.stall = 1'b1;
                    end
                end
            end
            REFILL: begin
                bus.stall    = 1'b1;
                bus.mem_req  = 1'b1;
                bus.mem_addr = {bus.addr[31:4], 4'b0};
                wr_offset    = beat_cnt;
                wr_data      = bus.mem_rdata;
                // The line stays invalid while partially filled, so an
                // abandoned refill can never produce a false hit.
                if (bus.mem_valid && !rst) begin
                    wr_word  = 1'b1;
                    line_set = (beat_cnt == 2'd3);
                    line_clr = (beat_cnt != 2'd3);
                end
            end
            WRITE: begin
                bus.stall     = !bus.mem_valid;
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {bus.addr[31:2], 2'b0};
                bus.mem_wdata = bus.wdata;
                wr_word       = bus.mem_valid && hit && !rst;
            end
            default: ;
        endcase
    end

endmodule
